// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receive and transmit blocks of the 8N1 link.
//   Contents:
//     DATA_BITS            - payload bits per frame (8N1 => 8)
//     DEFAULT_CLKS_PER_BIT - system clocks per serial bit (50 MHz / 9600 baud)
//     uart_state_e         - frame-level state encoding
//     half_bit()           - clock count to the centre of the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    typedef enum logic [2:0] {
        WAIT_IDLE,  // waiting for the line to be seen high before arming
        IDLE,       // armed, looking for a start-bit falling edge
        START,      // timing out to the centre of the start bit
        DATA,       // sampling the payload bits, LSB first
        STOP        // sampling the stop bit
    } uart_state_e;

    // Integer division: for odd bit periods the start sample lands just
    // before the true centre, which still leaves margin on both sides.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Bundles the serial input and the byte-level outputs of the UART receiver.
//   Signals:
//     rx          - serial line, idles high, asynchronous to the system clock
//     rx_data     - last correctly received byte
//     rx_done     - one-cycle strobe when rx_data is updated
//     busy        - a frame is being received
//     frame_error - one-cycle strobe when the stop bit was sampled low
//   Modports:
//     master - environment side: drives rx, consumes the byte outputs
//     slave  - receiver side: consumes rx, drives the byte outputs
// -----------------------------------------------------------------------------
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 busy;
    logic                 frame_error;

    modport master (
        output rx,
        input  rx_data,
        input  rx_done,
        input  busy,
        input  frame_error
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_done,
        output busy,
        output frame_error
    );

endinterface

// File: rtl/uart_rx_baud_counter.sv
// -----------------------------------------------------------------------------
// baud_counter_RX
//   Free-running bit-period counter for the UART receiver. The owner clears
//   it on every state entry and every sample, so the ticks are always
//   measured from the most recent decision point.
//   Ports:
//     clk       - system clock, rising edge
//     reset     - asynchronous, active-high reset
//     clear     - synchronous clear; counter reads 0 in the next cycle
//     half_tick - count has reached HALF-1 (centre of the start bit)
//     full_tick - count has reached CLKS_PER_BIT-1 (one full bit period)
//   CLKS_PER_BIT must be at least 4 so HALF-1 and CLKS_PER_BIT-1 are distinct
//   non-zero counts.
// -----------------------------------------------------------------------------
module baud_counter_RX
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign half_tick = (cnt == HALF_LAST);
    assign full_tick = (cnt == FULL_LAST);

    // Wrapping at the full count keeps the counter inside its range even in
    // states that do not clear it explicitly.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || full_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Receive end of the 8N1 serial link. The asynchronous line is brought into
//   the clock domain through a two-flop synchronizer, a falling edge arms the
//   start-bit check, and each bit is sampled at its centre using
//   baud_counter_RX. A good frame loads rx_data and pulses rx_done; a low
//   stop bit pulses frame_error and leaves rx_data untouched.
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-high reset
//     bus   - uart_rx_if.slave: rx in; rx_data, rx_done, busy, frame_error out
//   Parameter:
//     CLKS_PER_BIT - system clocks per serial bit, at least 4
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    // Synchronizer
    logic rx_meta;
    logic rx_s;

    // State machine
    uart_state_e state;
    uart_state_e state_next;

    // Datapath
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;

    // Baud counter interface
    logic cnt_clear;
    logic half_tick;
    logic full_tick;

    // Per-cycle decisions from the state machine
    logic shift_en;
    logic idx_clear;
    logic load_data;
    logic done_next;
    logic ferr_next;
    logic busy_next;

    // Registered outputs
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_done_q;
    logic                 busy_q;
    logic                 frame_error_q;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. Both flops reset low, so rx_s reads 0 straight
    // after reset; WAIT_IDLE keeps that from looking like a start bit.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b0;
            rx_s    <= 1'b0;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    baud_counter_RX #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_counter (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode. The counter is held clear in both idle
    // states so the first cycle of START always sees a count of 0.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        shift_en   = 1'b0;
        idx_clear  = 1'b0;
        load_data  = 1'b0;
        done_next  = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            WAIT_IDLE: begin
                cnt_clear = 1'b1;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                cnt_clear = 1'b1;
                if (!rx_s) begin
                    state_next = START;
                end
            end

            START: begin
                if (half_tick) begin
                    cnt_clear = 1'b1;
                    if (!rx_s) begin
                        idx_clear  = 1'b1;
                        state_next = DATA;
                    end else begin
                        // Line back high at mid-start: a glitch, not a frame.
                        state_next = IDLE;
                    end
                end
            end

            DATA: begin
                if (full_tick) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == LAST_IDX) begin
                        state_next = STOP;
                    end
                end
            end

            STOP: begin
                if (full_tick) begin
                    cnt_clear = 1'b1;
                    if (rx_s) begin
                        load_data  = 1'b1;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        // A low stop bit may be a break or a stuck line: wait
                        // for it to go high before looking for another start.
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end

            default: begin
                state_next = WAIT_IDLE;
            end
        endcase

        // Registering busy from the next state makes it rise the cycle after
        // the start edge is seen and fall together with the end-of-frame strobe.
        busy_next = (state_next == START) || (state_next == DATA) ||
                    (state_next == STOP);
    end

    // -------------------------------------------------------------------------
    // Shift register, bit index and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx       <= '0;
            shift_reg     <= '0;
            rx_data_q     <= '0;
            rx_done_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            if (idx_clear) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            // LSB arrives first, so bit_idx addresses the payload directly.
            if (shift_en) begin
                shift_reg[bit_idx] <= rx_s;
            end

            if (load_data) begin
                rx_data_q <= shift_reg;
            end

            rx_done_q     <= done_next;
            frame_error_q <= ferr_next;
            busy_q        <= busy_next;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_done     = rx_done_q;
    assign bus.busy        = busy_q;
    assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx with CLKS_PER_BIT = 8. A monitor records
//   every rx_done / frame_error strobe and every busy interval; a frame-level
//   model predicts which strobes must appear and what rx_data must read.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB        = 8;
    localparam int HALF       = CPB / 2;
    localparam int FRAME_CLKS = 10 * CPB;
    localparam int BUSY_CLKS  = HALF + 9 * CPB;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Monitor state
    ev_t  ev_q[$];
    int   busy_runs[$];
    int   cyc          = 0;
    int   busy_run     = 0;
    int   busy_cycles  = 0;
    int   overlap_errs = 0;
    int   long_errs    = 0;
    int   align_errs   = 0;
    logic prev_done    = 1'b0;
    logic prev_ferr    = 1'b0;
    logic prev_busy    = 1'b0;

    // Reference model
    ev_t        exp_q[$];
    logic [7:0] ref_data = 8'h00;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.rx_done && bus.frame_error) overlap_errs++;
        if ((bus.rx_done && prev_done) || (bus.frame_error && prev_ferr)) long_errs++;
        if ((bus.rx_done && !prev_done) || (bus.frame_error && !prev_ferr)) begin
            if (bus.busy || !prev_busy) align_errs++;
            ev_q.push_back('{is_err: bus.frame_error, data: bus.rx_data, cyc: cyc});
        end
        if (bus.busy) begin
            busy_run++;
            busy_cycles++;
        end else if (busy_run > 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
        prev_done = bus.rx_done;
        prev_ferr = bus.frame_error;
        prev_busy = bus.busy;
    end

    // ---------------- stimulus and model helpers ----------------
    task automatic send_bit(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Slots 0..9 are start, d0..d7, stop; even slots last d_even clocks.
    task automatic send_frame_skew(input logic [7:0] b, input logic stop,
                                   input int d_even, input int d_odd);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) send_bit(bits[j], (j % 2 == 0) ? d_even : d_odd);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_frame_skew(b, stop, CPB, CPB);
    endtask

    // A good stop bit delivers the byte; a bad one reports an error while the
    // previously delivered byte stays visible.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            ref_data = b;
            exp_q.push_back('{is_err: 1'b0, data: b, cyc: 0});
        end else begin
            exp_q.push_back('{is_err: 1'b1, data: ref_data, cyc: 0});
        end
    endtask

    task automatic clear_logs();
        ev_q.delete();
        exp_q.delete();
        busy_runs.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.rx_data, bus.rx_done, bus.busy, bus.frame_error} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, expected 000",
                     {bus.rx_data, bus.rx_done, bus.busy, bus.frame_error});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        clear_logs();
        model_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1, 2 * CPB);
        tests++;
        if (ev_q.size() !== 1) begin
            fails++;
            $display("FAIL single_count: got %0d strobes, expected 1", ev_q.size());
        end else begin
            tests++;
            if (ev_q[0].is_err !== exp_q[0].is_err || ev_q[0].data !== exp_q[0].data) begin
                fails++;
                $display("FAIL single_data: got err=%0d data=%h, expected err=%0d data=%h",
                         ev_q[0].is_err, ev_q[0].data, exp_q[0].is_err, exp_q[0].data);
            end
        end
        tests++;
        if (busy_runs.size() !== 1) begin
            fails++;
            $display("FAIL single_busy_runs: got %0d intervals, expected 1", busy_runs.size());
        end else begin
            tests++;
            if (busy_runs[0] !== BUSY_CLKS) begin
                fails++;
                $display("FAIL single_busy_len: got %0d, expected %0d", busy_runs[0], BUSY_CLKS);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        model_frame(8'h00, 1'b1);
        model_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, 2 * CPB);
        tests++;
        if (ev_q.size() !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d strobes, expected 2", ev_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (ev_q[i].is_err !== exp_q[i].is_err || ev_q[i].data !== exp_q[i].data) begin
                    fails++;
                    $display("FAIL b2b_data%0d: got err=%0d data=%h, expected err=%0d data=%h",
                             i, ev_q[i].is_err, ev_q[i].data, exp_q[i].is_err, exp_q[i].data);
                end
            end
            tests++;
            if (ev_q[1].cyc - ev_q[0].cyc !== FRAME_CLKS) begin
                fails++;
                $display("FAIL b2b_spacing: got %0d cycles, expected %0d",
                         ev_q[1].cyc - ev_q[0].cyc, FRAME_CLKS);
            end
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        send_bit(1'b0, 2);
        send_bit(1'b1, 3 * CPB);
        tests++;
        if (ev_q.size() !== 0) begin
            fails++;
            $display("FAIL glitch_strobes: got %0d strobes, expected 0", ev_q.size());
        end
        tests++;
        if (busy_runs.size() !== 1 || busy_runs[0] < 1 || busy_runs[0] > 5) begin
            fails++;
            $display("FAIL glitch_busy: got %0d intervals (first %0d), expected 1 of 1..5 cycles",
                     busy_runs.size(), (busy_runs.size() > 0) ? busy_runs[0] : 0);
        end
    endtask

    task automatic test_frame_error();
        int busy_before;
        clear_logs();
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0);
        busy_before = busy_cycles;
        send_bit(1'b0, 20);
        tests++;
        if (busy_cycles - busy_before !== 0) begin
            fails++;
            $display("FAIL ferr_low_line_busy: got %0d busy cycles, expected 0",
                     busy_cycles - busy_before);
        end
        send_bit(1'b1, CPB);
        model_frame(8'h81, 1'b1);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1, 2 * CPB);
        tests++;
        if (ev_q.size() !== 2) begin
            fails++;
            $display("FAIL ferr_count: got %0d strobes, expected 2", ev_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (ev_q[i].is_err !== exp_q[i].is_err || ev_q[i].data !== exp_q[i].data) begin
                    fails++;
                    $display("FAIL ferr_event%0d: got err=%0d data=%h, expected err=%0d data=%h",
                             i, ev_q[i].is_err, ev_q[i].data, exp_q[i].is_err, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int busy_before;
        clear_logs();
        // Start bit, data bits 0..3, then half of data bit 4.
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(1'b0, CPB);
        send_bit(1'b0, HALF);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.rx_data, bus.rx_done, bus.busy, bus.frame_error} !== 11'd0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h, expected 000",
                     {bus.rx_data, bus.rx_done, bus.busy, bus.frame_error});
        end
        repeat (2) @(negedge clk);
        ref_data = 8'h00;
        // Release with the line still low: nothing may start until it goes high.
        reset = 1'b0;
        busy_before = busy_cycles;
        send_bit(1'b0, 20);
        tests++;
        if (busy_cycles - busy_before !== 0 || ev_q.size() !== 0) begin
            fails++;
            $display("FAIL midreset_quiet: got %0d busy cycles and %0d strobes, expected 0 and 0",
                     busy_cycles - busy_before, ev_q.size());
        end
        send_bit(1'b1, CPB);
        ev_q.delete();
        model_frame(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1);
        send_bit(1'b1, 2 * CPB);
        tests++;
        if (ev_q.size() !== 1) begin
            fails++;
            $display("FAIL midreset_count: got %0d strobes, expected 1", ev_q.size());
        end else begin
            tests++;
            if (ev_q[0].is_err !== exp_q[0].is_err || ev_q[0].data !== exp_q[0].data) begin
                fails++;
                $display("FAIL midreset_data: got err=%0d data=%h, expected err=%0d data=%h",
                         ev_q[0].is_err, ev_q[0].data, exp_q[0].is_err, exp_q[0].data);
            end
        end
    endtask

    // Bit lengths of 7 and 9 clocks alternate so the edge drift stays within
    // one clock; a uniform +-1 over ten bits would walk past the half-bit point.
    task automatic test_skew();
        int d_even;
        int d_odd;
        for (int k = 0; k < 2; k++) begin
            d_even = (k == 0) ? CPB - 1 : CPB + 1;
            d_odd  = (k == 0) ? CPB + 1 : CPB - 1;
            clear_logs();
            model_frame(8'h96, 1'b1);
            send_frame_skew(8'h96, 1'b1, d_even, d_odd);
            send_bit(1'b1, 2 * CPB);
            tests++;
            if (ev_q.size() !== 1) begin
                fails++;
                $display("FAIL skew%0d_count: got %0d strobes, expected 1", k, ev_q.size());
            end else begin
                tests++;
                if (ev_q[0].is_err !== exp_q[0].is_err || ev_q[0].data !== exp_q[0].data) begin
                    fails++;
                    $display("FAIL skew%0d_data: got err=%0d data=%h, expected err=%0d data=%h",
                             k, ev_q[0].is_err, ev_q[0].data, exp_q[0].is_err, exp_q[0].data);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        int         gap;
        clear_logs();
        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            // After a bad stop bit the line must be seen high before a new start.
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            model_frame(b, stop);
            send_frame(b, stop);
            if (gap > 0) send_bit(1'b1, gap * CPB);
        end
        send_bit(1'b1, 2 * CPB);
        tests++;
        if (ev_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL random_count: got %0d strobes, expected %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests++;
                if (ev_q[i].is_err !== exp_q[i].is_err || ev_q[i].data !== exp_q[i].data) begin
                    fails++;
                    $display("FAIL random_event%0d: got err=%0d data=%h, expected err=%0d data=%h",
                             i, ev_q[i].is_err, ev_q[i].data, exp_q[i].is_err, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_protocol();
        tests++;
        if (overlap_errs !== 0) begin
            fails++;
            $display("FAIL strobe_overlap: got %0d cycles with both strobes, expected 0", overlap_errs);
        end
        tests++;
        if (long_errs !== 0) begin
            fails++;
            $display("FAIL strobe_width: got %0d multi-cycle strobes, expected 0", long_errs);
        end
        tests++;
        if (align_errs !== 0) begin
            fails++;
            $display("FAIL busy_strobe_align: got %0d misaligned busy falls, expected 0", align_errs);
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        reset  = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_skew();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive end of the team's 8N1 serial link, pairing with the existing transmitter. It oversamples the asynchronous serial line on the system clock, locks onto the start bit's falling edge and samples each bit at its centre. It then presents the received byte with a one-cycle `rx_done` strobe, or flags a framing error. It sits between the pad-side `rx` pin and the byte-level consumer, for example a FIFO or command decoder.

## Interface
- `CLKS_PER_BIT`, default 5208: system clock cycles per serial bit (50 MHz / 9600 baud). Must be ≥ 4.
- `clk` input, 1: system clock, rising-edge.
- `reset` input, 1: asynchronous, active-high reset.
- `rx` input, 1: serial line, asynchronous to `clk`, idles high.
- `rx_data` output, 8: last correctly received byte. Held until the next valid frame.
- `rx_done` output, 1: one-cycle pulse when `rx_data` is updated.
- `busy` output, 1: high while a frame is being received (START, DATA, STOP states).
- `frame_error` output, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 0. `rx_s` is the second flop's output. All decisions use `rx_s`.
- State machine:
  - **WAIT_IDLE** (reset state): go to IDLE when `rx_s` = 1. This guards against a line that is already low after reset.
  - **IDLE**: when `rx_s` = 0, clear the counter and go to START.
  - **START**: count to HALF−1, where HALF = CLKS_PER_BIT/2 using integer division.
    - At the sample point, if `rx_s` = 0, clear the counter and bit index, then go to DATA.
    - If `rx_s` = 1, the start was a glitch: go to IDLE. No output changes.
  - **DATA**: count to CLKS_PER_BIT−1, then sample `rx_s` into shift-register bit[index]. Data is LSB first.
    - The index increments each sample.
    - After index 7 is sampled, clear the counter and go to STOP.
  - **STOP**: count to CLKS_PER_BIT−1, then sample `rx_s`.
    - If 1: load `rx_data` from the shift register, pulse `rx_done`, go to IDLE.
    - If 0: pulse `frame_error`, leave `rx_data` unchanged, go to WAIT_IDLE.
- Counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits. The counter clears on every sample and on every state entry.
- All outputs are registered.
- Reset values: `rx_data` = 8'h00, `rx_done` = 0, `busy` = 0, `frame_error` = 0, state = WAIT_IDLE, shift register = 0.

## Timing
- Let cycle t0 be the first cycle in IDLE with `rx_s` = 0. This is 2–3 cycles after the falling edge on `rx`.
- Sample points:
  - Start bit at t0+HALF.
  - Data bit k at t0+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit at t0+HALF+9·CLKS_PER_BIT.
- `rx_done` or `frame_error` is high in the cycle after the stop sample, for exactly one cycle. `rx_data` is valid in that same cycle.
- `busy` rises the cycle after t0. It falls in the same cycle that `rx_done`/`frame_error` rises.
- After a valid stop, the block is back in IDLE the cycle after the sample. A back-to-back start edge arriving half a bit later is therefore caught; zero idle bits between frames are supported.
- Reset asserted mid-frame: the block immediately returns to the reset state and the partial byte is discarded. After release, reception restarts only once `rx_s` has been high.
- No other strobe is raised while `rx_done` is high. `rx_done` and `frame_error` are never high together.

## Structure
- Shared package `uart_pkg`:
  - State enum (WAIT_IDLE, IDLE, START, DATA, STOP).
  - `DATA_BITS` = 8.
  - Default `CLKS_PER_BIT`.
  - These are shared with the TX side.
- One natural sub-module, `baud_counter_RX`: a parameterised counter with clear input and `half_tick`/`full_tick` outputs, instantiated once.
- The synchronizer, state machine and shift register live in `uart_rx`.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8.
- Reset with `rx` high, then send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → one `rx_done` pulse, `rx_data` = 8'hA5, `frame_error` stays 0, `busy` high for the frame.
- Send 0x00 and then 0xFF back-to-back with no idle bit → two `rx_done` pulses 80 cycles apart, with `rx_data` 8'h00 then 8'hFF.
- Pulse `rx` low for 2 cycles only → START aborts at the half-bit sample; no `rx_done`, no `frame_error`; `busy` high for ≤ 5 cycles and then low.
- Send 0x3C with the stop bit driven 0, then hold `rx` low for 20 cycles, then high, then send 0x81 → `frame_error` pulses once with `rx_data` still at its prior value; no new start while the line is low; the next frame gives `rx_data` = 8'h81.
- Assert `reset` during data bit 4 of a frame, release it, then send 0x5A → outputs read 0 during reset, no stray `rx_done`, and the next frame gives 8'h5A.
- Skew each bit's duration by ±1 cycle (7 or 9 cycles per bit) while sending 0x96 → `rx_data` = 8'h96, with no error in either case.
